sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO; next-generation replacement for the fixed 8-bit FIFO under UVM test.

---
 rtl/sync_fifo_param.sv | 149 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count,
// error pulses, synchronous flush and optional first-word-fall-through.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush (priority over wr_en/rd_en)
//   data_in      write data, WIDTH bits
//   wr_en        write request
//   rd_en        read request
//   data_out     read data (registered, or head word when FWFT=1)
//   full         fifo_cnt == DEPTH
//   empty        fifo_cnt == 0
//   almost_full  fifo_cnt >= AF_LEVEL
//   almost_empty fifo_cnt <= AE_LEVEL
//   fifo_cnt     occupancy 0..DEPTH
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a rejected read
module sync_fifo_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = 14,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned FWFT     = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (WIDTH < 1 || DEPTH < 4 ||
       (DEPTH & (DEPTH - 1)) != 0 ||
       AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
       AE_LEVEL > DEPTH - 1 || FWFT > 1)
   begin : g_bad_param
      $error("sync_fifo_param: illegal parameters");
   end

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] dout_q, dout_d;

   logic             rd_acc;
   logic             wr_acc;
   logic             do_wr;
   logic             is_empty;
   logic             is_full;
   logic [WIDTH-1:0] head;

   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == CW'(DEPTH));

   // A read frees a slot in the same edge, so a full FIFO
   // still takes a simultaneous write.
   assign rd_acc = rd_en && !is_empty;
   assign wr_acc = wr_en && (!is_full || rd_acc);
   assign do_wr  = wr_acc && !clr;

   assign head = mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dout_d   = dout_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         dout_d   = '0;
      end else begin
         ovf_d = wr_en && !wr_acc;
         unf_d = rd_en && !rd_acc;
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = head;
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         dout_q   <= dout_d;
      end
   end

   // Storage carries no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   // In FWFT mode the head word is shown directly; forcing zero
   // while empty keeps the post-reset output deterministic.
   assign data_out = (FWFT != 0)
                   ? (is_empty ? '0 : head)
                   : dout_q;

   assign full         = is_full;
   assign empty        = is_empty;
   assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
   assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
   assign fifo_cnt     = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param.
// Standard-mode and FWFT instances share clock and reset.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       clr = 1'b0;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       full, empty, af, ae, ovf, unf;
   logic [4:0] cnt;

   logic       f_clr = 1'b0;
   logic       f_wr = 1'b0;
   logic       f_rd = 1'b0;
   logic [7:0] f_din = '0;
   logic [7:0] f_dout;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0] f_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.FWFT(0)) u_std (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .data_in      (din),
      .wr_en        (wr),
      .rd_en        (rd),
      .data_out     (dout),
      .full         (full),
      .empty        (empty),
      .almost_full  (af),
      .almost_empty (ae),
      .fifo_cnt     (cnt),
      .overflow     (ovf),
      .underflow    (unf)
   );

   sync_fifo_param #(.FWFT(1)) u_fw (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (f_clr),
      .data_in      (f_din),
      .wr_en        (f_wr),
      .rd_en        (f_rd),
      .data_out     (f_dout),
      .full         (f_full),
      .empty        (f_empty),
      .almost_full  (f_af),
      .almost_empty (f_ae),
      .fifo_cnt     (f_cnt),
      .overflow     (f_ovf),
      .underflow    (f_unf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ae", 32'(ae), 1);
      chk("rst_af", 32'(af), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_unf", 32'(unf), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_f_empty", 32'(f_empty), 1);
      rst_n = 1'b1;
      tick();

      // fill 0x01..0x10
      wr = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         din = 8'(i);
         tick();
         chk("fill_cnt", 32'(cnt), 32'(i));
         chk("fill_af", 32'(af), 32'(i >= 14));
         chk("fill_ae", 32'(ae), 32'(i <= 2));
         chk("fill_full", 32'(full), 32'(i == 16));
      end
      din = 8'h77;
      tick();
      chk("ovf_pulse", 32'(ovf), 1);
      chk("ovf_cnt", 32'(cnt), 16);
      wr = 1'b0;
      tick();
      chk("ovf_clear", 32'(ovf), 0);
      chk("ovf_cnt2", 32'(cnt), 16);

      // drain 16 words
      rd = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("drain_dout", 32'(dout), 32'(i));
         chk("drain_cnt", 32'(cnt), 32'(16 - i));
         chk("drain_ae", 32'(ae), 32'(16 - i <= 2));
         chk("drain_empty", 32'(empty), 32'(i == 16));
      end
      tick();
      chk("unf_pulse", 32'(unf), 1);
      chk("unf_dout", 32'(dout), 32'h10);
      chk("unf_cnt", 32'(cnt), 0);
      rd = 1'b0;
      tick();
      chk("unf_clear", 32'(unf), 0);

      // full with simultaneous read and write
      wr = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = 8'(8'h20 + i);
         tick();
      end
      chk("f3_full", 32'(full), 1);
      din = 8'hAA;
      rd = 1'b1;
      tick();
      chk("f3_cnt", 32'(cnt), 16);
      chk("f3_ovf", 32'(ovf), 0);
      chk("f3_dout", 32'(dout), 32'h20);
      wr = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("f3_drain", 32'(dout),
             (k == 16) ? 32'hAA : 32'(8'h20 + k));
      end
      rd = 1'b0;
      tick();
      chk("f3_empty", 32'(empty), 1);

      // empty with simultaneous read and write
      wr = 1'b1;
      rd = 1'b1;
      din = 8'h55;
      tick();
      chk("e4_unf", 32'(unf), 1);
      chk("e4_cnt", 32'(cnt), 1);
      chk("e4_hold", 32'(dout), 32'hAA);
      wr = 1'b0;
      tick();
      chk("e4_dout", 32'(dout), 32'h55);
      chk("e4_cnt2", 32'(cnt), 0);
      chk("e4_unf2", 32'(unf), 0);
      rd = 1'b0;
      tick();

      // FWFT head visibility
      f_wr = 1'b1;
      f_din = 8'h3C;
      tick();
      f_wr = 1'b0;
      chk("fw_empty", 32'(f_empty), 0);
      chk("fw_head", 32'(f_dout), 32'h3C);
      tick();
      chk("fw_hold", 32'(f_dout), 32'h3C);
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
      chk("fw_rd_empty", 32'(f_empty), 1);
      chk("fw_rd_cnt", 32'(f_cnt), 0);
      f_wr = 1'b1;
      f_din = 8'h11;
      tick();
      chk("fw_h1", 32'(f_dout), 32'h11);
      f_din = 8'h22;
      tick();
      f_wr = 1'b0;
      chk("fw_h1b", 32'(f_dout), 32'h11);
      f_rd = 1'b1;
      tick();
      chk("fw_h2", 32'(f_dout), 32'h22);
      tick();
      f_rd = 1'b0;
      chk("fw_empty2", 32'(f_empty), 1);

      // wrap: write 10, read 8, write 12
      wr = 1'b1;
      for (int k = 0; k < 10; k++) begin
         din = 8'(8'h40 + k);
         tick();
      end
      wr = 1'b0;
      rd = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("w6_rd", 32'(dout), 32'(8'h40 + k));
      end
      rd = 1'b0;
      wr = 1'b1;
      for (int k = 0; k < 12; k++) begin
         din = 8'(8'h50 + k);
         tick();
      end
      wr = 1'b0;
      chk("w6_cnt", 32'(cnt), 14);
      chk("w6_af", 32'(af), 1);
      chk("w6_full", 32'(full), 0);
      rd = 1'b1;
      for (int k = 0; k < 14; k++) begin
         tick();
         chk("w6_order", 32'(dout),
             (k < 2) ? 32'(8'h48 + k)
                     : 32'(8'h50 + k - 2));
      end
      rd = 1'b0;
      tick();
      chk("w6_empty", 32'(empty), 1);

      // flush with concurrent write
      wr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din = 8'(8'h60 + k);
         tick();
      end
      wr = 1'b0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("c6_pre", 32'(dout), 32'h60);
      chk("c6_precnt", 32'(cnt), 2);
      clr = 1'b1;
      wr = 1'b1;
      din = 8'hEE;
      tick();
      clr = 1'b0;
      wr = 1'b0;
      chk("clr_cnt", 32'(cnt), 0);
      chk("clr_empty", 32'(empty), 1);
      chk("clr_dout", 32'(dout), 0);
      chk("clr_ovf", 32'(ovf), 0);
      chk("clr_unf", 32'(unf), 0);

      // asynchronous reset mid-burst
      wr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din = 8'(8'h70 + k);
         tick();
      end
      rd = 1'b1;
      din = 8'h73;
      tick();
      chk("r6_dout", 32'(dout), 32'h70);
      chk("r6_cnt", 32'(cnt), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_cnt", 32'(cnt), 0);
      chk("ar_empty", 32'(empty), 1);
      chk("ar_full", 32'(full), 0);
      chk("ar_ae", 32'(ae), 1);
      chk("ar_af", 32'(af), 0);
      chk("ar_dout", 32'(dout), 0);
      chk("ar_ovf", 32'(ovf), 0);
      chk("ar_unf", 32'(unf), 0);
      wr = 1'b0;
      rd = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_after", 32'(cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
